// File: rtl/des_iter_core.sv
// Iterative rotate/xor/add block cipher core: one round unit reused ROUNDS times,
// encrypt/decrypt, valid/ready handshakes, abort and post-operation zeroisation.
module des_iter_core #(
    parameter int unsigned DATA_W = 56,
    parameter int unsigned ROUNDS = 16,
    parameter int unsigned SROT   = 3,
    parameter int unsigned KROT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_key,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int unsigned RND_W = 6;
    // Decrypt starts from the last round key, reached by a fixed rotation of the key.
    localparam int unsigned KDEC_ROT = (KROT * (ROUNDS - 1)) % DATA_W;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone, StZero} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic [DATA_W-1:0] k_q, k_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              mode_q, mode_d;
    logic [RND_W-1:0]  rnd_q, rnd_d;

    logic [DATA_W-1:0] rnd_ext;
    logic [DATA_W-1:0] enc_round;
    logic [DATA_W-1:0] dec_round;
    logic [DATA_W-1:0] result;
    logic              last_round;
    logic              clear;

    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x,
                                               input int unsigned n);
        logic [2*DATA_W-1:0] d;
        d = {x, x} << n;
        return d[2*DATA_W-1 -: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                               input int unsigned n);
        logic [2*DATA_W-1:0] d;
        d = {x, x} >> n;
        return d[DATA_W-1:0];
    endfunction

    assign rnd_ext    = {{(DATA_W - RND_W){1'b0}}, rnd_q};
    assign enc_round  = rotl(s_q ^ k_q, SROT) + rnd_ext;
    assign dec_round  = rotr(s_q - rnd_ext, SROT) ^ k_q;
    assign result     = mode_q ? (s_q ^ key_q) : s_q;
    assign last_round = mode_q ? (rnd_q == '0) : (rnd_q == LAST_RND);

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        k_d       = k_q;
        key_d     = key_q;
        mode_d    = mode_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        clear     = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    s_d     = in_mode ? in_data : (in_data ^ in_key);
                    k_d     = in_mode ? rotl(in_key, KDEC_ROT) : in_key;
                    key_d   = in_key;
                    mode_d  = in_mode;
                    rnd_d   = in_mode ? LAST_RND : '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    clear   = 1'b1;
                    state_d = StZero;
                end else begin
                    s_d   = mode_q ? dec_round : enc_round;
                    k_d   = mode_q ? rotr(k_q, KROT) : rotl(k_q, KROT);
                    rnd_d = mode_q ? (rnd_q - 1'b1) : (rnd_q + 1'b1);
                    if (last_round) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Abort wins over a simultaneous consumer handshake; the result never shows.
                if (abort) begin
                    clear   = 1'b1;
                    state_d = StZero;
                end else begin
                    out_valid = 1'b1;
                    out_data  = result;
                    if (out_ready) begin
                        clear   = 1'b1;
                        state_d = StZero;
                    end
                end
            end
            StZero: begin
                clear   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                clear   = 1'b1;
                state_d = StIdle;
            end
        endcase

        if (clear) begin
            s_d    = '0;
            k_d    = '0;
            key_d  = '0;
            mode_d = 1'b0;
            rnd_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            k_q     <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            rnd_q   <= rnd_d;
        end
    end

endmodule

// File: tb/tb_des_iter_core.sv
// Directed bench for des_iter_core: an 8-bit/2-round instance with hand-computed
// vectors and a default 56-bit instance exercised with random encrypt/decrypt round trips.
module tb_des_iter_core;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 8-bit, 2-round instance
    logic       a_in_valid = 1'b0, a_in_ready, a_in_mode = 1'b0;
    logic [7:0] a_in_data = '0, a_in_key = '0, a_out_data;
    logic       a_abort = 1'b0, a_out_valid, a_out_ready = 1'b0, a_busy;

    // default 56-bit, 16-round instance
    logic        b_in_valid = 1'b0, b_in_ready, b_in_mode = 1'b0;
    logic [55:0] b_in_data = '0, b_in_key = '0, b_out_data;
    logic        b_abort = 1'b0, b_out_valid, b_out_ready = 1'b0, b_busy;

    int tests = 0;
    int fails = 0;
    logic zbad = 1'b0;

    des_iter_core #(.DATA_W(8), .ROUNDS(2), .SROT(1), .KROT(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mode(a_in_mode), .in_data(a_in_data), .in_key(a_in_key), .abort(a_abort),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
    );

    des_iter_core dut56 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_data(b_in_data), .in_key(b_in_key), .abort(b_abort),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] rl56(input logic [55:0] x, input int n);
        return (n == 0) ? x : ((x << n) | (x >> (56 - n)));
    endfunction

    function automatic logic [55:0] enc56(input logic [55:0] d, input logic [55:0] k);
        logic [55:0] s;
        s = d ^ k;
        for (int i = 0; i < 16; i++) begin
            s = rl56(s ^ rl56(k, i % 56), 3) + 56'(i);
        end
        return s;
    endfunction

    // Accept one request, scramble the inputs, wait (bounded) for out_valid.
    task automatic a_go(input logic m, input logic [7:0] d, input logic [7:0] k, output int lat);
        a_in_mode = m; a_in_data = d; a_in_key = k; a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0; a_in_mode = ~m; a_in_data = ~d; a_in_key = ~k;
        lat = 0;
        while (!a_out_valid && lat < 200) begin
            tick;
            lat++;
        end
    endtask

    task automatic b_go(input logic m, input logic [55:0] d, input logic [55:0] k,
                        output int lat);
        b_in_mode = m; b_in_data = d; b_in_key = k; b_in_valid = 1'b1;
        tick;
        b_in_valid = 1'b0; b_in_data = ~d; b_in_key = ~k;
        lat = 0;
        while (!b_out_valid && lat < 200) begin
            if (b_out_data !== '0) zbad = 1'b1;
            tick;
            lat++;
        end
    endtask

    task automatic a_ack;
        a_out_ready = 1'b1;
        tick;
        a_out_ready = 1'b0;
        tick;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, low, got;
        logic stable;
        logic [7:0] res;
        logic [55:0] d, k, c;

        #3;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_busy", a_busy, 0);
        check("rst56_out_data", b_out_data, 0);
        #9 rst = 1'b1;
        tick;

        // encrypt 00 / key 01 -> 05 after two rounds
        a_go(1'b0, 8'h00, 8'h01, lat);
        check("enc_latency", lat, 2);
        check("enc_data", a_out_data, 8'h05);
        check("run_in_ready", a_in_ready, 0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (a_out_valid !== 1'b1 || a_out_data !== 8'h05) stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        a_out_ready = 1'b1;
        tick;
        a_out_ready = 1'b0;
        check("zero_out_valid", a_out_valid, 0);
        check("zero_out_data", a_out_data, 0);
        check("zero_in_ready", a_in_ready, 0);
        check("zero_busy", a_busy, 1);
        check("zero_s", dut8.s_q, 0);
        check("zero_k", dut8.k_q, 0);
        check("zero_key", dut8.key_q, 0);
        tick;
        check("idle_in_ready", a_in_ready, 1);
        check("idle_busy", a_busy, 0);

        // decrypt vectors
        a_go(1'b1, 8'h05, 8'h01, lat);
        check("dec_latency", lat, 2);
        check("dec_data", a_out_data, 8'h00);
        a_ack;
        a_go(1'b1, 8'h67, 8'h3C, lat);
        check("dec2_data", a_out_data, 8'hA5);
        a_ack;

        // back-to-back with out_ready held high
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 8'h00; a_in_key = 8'h01;
        tick;
        a_in_mode = 1'b1; a_in_data = 8'h05;
        low = 0; got = 0; res = '0;
        while (!a_in_ready && low < 50) begin
            if (a_out_valid) begin res = a_out_data; got++; end
            low++;
            tick;
        end
        check("b2b_enc_gap", low, 4);
        check("b2b_enc_data", res, 8'h05);
        check("b2b_enc_pulses", got, 1);
        tick;
        a_in_valid = 1'b0;
        low = 0; got = 0; res = 8'hFF;
        while (!a_in_ready && low < 50) begin
            if (a_out_valid) begin res = a_out_data; got++; end
            low++;
            tick;
        end
        check("b2b_dec_gap", low, 4);
        check("b2b_dec_data", res, 8'h00);
        check("b2b_dec_pulses", got, 1);
        a_out_ready = 1'b0;

        // abort together with out_ready in DONE
        a_go(1'b0, 8'hA5, 8'h3C, lat);
        check("pre_abort_data", a_out_data, 8'h67);
        a_abort = 1'b1; a_out_ready = 1'b1;
        #1;
        check("abort_done_valid", a_out_valid, 0);
        check("abort_done_data", a_out_data, 0);
        tick;
        a_abort = 1'b0; a_out_ready = 1'b0;
        check("abort_done_zero_s", dut8.s_q, 0);
        check("abort_done_zero_key", dut8.key_q, 0);
        check("abort_done_in_ready", a_in_ready, 0);
        check("abort_done_valid2", a_out_valid, 0);
        tick;
        check("abort_done_idle", a_in_ready, 1);

        // abort mid-RUN on the 16-round core
        b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_data = 56'h123456789ABCDE;
        b_in_key = 56'h0F1E2D3C4B5A69;
        tick;
        b_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        check("abort_run_rnd", dut56.rnd_q, 4);
        b_abort = 1'b1;
        tick;
        b_abort = 1'b0;
        check("abort_run_valid", b_out_valid, 0);
        check("abort_run_busy", b_busy, 1);
        check("abort_run_s", dut56.s_q, 0);
        check("abort_run_k", dut56.k_q, 0);
        check("abort_run_key", dut56.key_q, 0);
        check("abort_run_rnd0", dut56.rnd_q, 0);
        tick;
        check("abort_run_idle", b_in_ready, 1);
        check("abort_run_no_valid", b_out_valid, 0);

        // asynchronous reset between edges mid-RUN
        a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 8'h11; a_in_key = 8'h22;
        tick;
        a_in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_in_ready", a_in_ready, 1);
        check("async_busy", a_busy, 0);
        check("async_out_valid", a_out_valid, 0);
        check("async_s", dut8.s_q, 0);
        #10 rst = 1'b1;
        tick;
        a_go(1'b0, 8'hA5, 8'h3C, lat);
        check("post_rst_latency", lat, 2);
        check("post_rst_data", a_out_data, 8'h67);
        a_ack;

        // 56-bit random round trips
        b_out_ready = 1'b1;
        for (int n = 0; n < 500; n++) begin
            d = 56'({$urandom(), $urandom()});
            k = 56'({$urandom(), $urandom()});
            b_go(1'b0, d, k, lat);
            c = b_out_data;
            check("rt_enc", c, enc56(d, k));
            tick;
            if (b_out_data !== '0) zbad = 1'b1;
            tick;
            b_go(1'b1, c, k, lat);
            check("rt_dec", b_out_data, d);
            tick;
            tick;
        end
        check("rt_latency", lat, 16);
        check("rt_zero_when_invalid", zbad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/des_iter_core.md
Name: des_iter_core

Overview:
- Parametrised, iterative successor to the fixed 56-bit unrolled cipher pipeline.
- One round hardware unit reused for ROUNDS cycles: configurable width, round count, rotation amounts.
- Adds encrypt/decrypt mode, valid/ready handshakes with backpressure, abort, and zeroisation of key/state after every operation.
- Sits between the host request interface and the result buffer.

Parameters:
DATA_W, 56, block and key width in bits (>=8)
ROUNDS, 16, number of rounds (2..63)
SROT, 3, state left-rotate per round (0 < SROT < DATA_W)
KROT, 1, key left-rotate per round (0 <= KROT < DATA_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  core can accept request
in_mode  in  1  0 = encrypt, 1 = decrypt
in_data  in  DATA_W  plaintext/ciphertext
in_key  in  DATA_W  key
abort  in  1  cancel current operation
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  result, zero when out_valid=0
busy  out  1  high in RUN, DONE or ZERO

Behaviour:
- Arithmetic: rotl/rotr are rotations over DATA_W bits; + and - are mod 2^DATA_W; round index i is zero-extended.
- Reset (rst=0, async): state=IDLE; s, k, key_r, mode_r, rnd all 0; in_ready=1, out_valid=0, out_data=0, busy=0.
- Key schedule: k_i = rotl(key, KROT*i mod DATA_W).
- Encrypt:
  - s_0 = in_data ^ key.
  - Round i = 0..ROUNDS-1: s_{i+1} = rotl(s_i ^ k_i, SROT) + i.
  - Result = s_ROUNDS.
- Decrypt:
  - s = in_data; k loads k_{ROUNDS-1} via constant rewiring.
  - Round i = ROUNDS-1 down to 0: s <= rotr(s - i, SROT) ^ k_i; k <= rotr(k, KROT).
  - Result = s ^ key_r.
- FSM IDLE -> RUN -> DONE -> ZERO -> IDLE:
  - IDLE: in_ready=1. On in_valid&in_ready: load s, k, key_r, mode_r. rnd = 0 (encrypt) or ROUNDS-1 (decrypt). Go to RUN.
  - RUN: one round per cycle; rnd increments (encrypt) or decrements (decrypt). After the ROUNDS-th round go to DONE.
  - DONE: out_valid=1; out_data holds the result stable until out_valid&out_ready, then go to ZERO.
  - ZERO: clear s, k, key_r, rnd to 0 for one cycle, then go to IDLE.
- Latency: accept at edge e0, rounds at edges e1..eROUNDS, out_valid high from eROUNDS until the handshake. Minimum issue interval is ROUNDS+2 cycles with out_ready held high.
- in_ready is low in RUN, DONE and ZERO; no new request is accepted until back in IDLE.
- abort:
  - In RUN or DONE: go to ZERO next edge; out_valid drops immediately; no result delivered.
  - Abort takes priority over a simultaneous out_ready in DONE.
  - In IDLE and ZERO, abort is ignored.
- out_data is forced to 0 whenever out_valid=0; intermediate state and key never reach outputs.
- Reset mid-operation: immediate return to the reset values above; no partial result emitted.
- Changes on in_data, in_key or in_mode after acceptance have no effect.

Test Plan:
1. DATA_W=8, ROUNDS=2, SROT=1, KROT=1; encrypt in_key=0x01, in_data=0x00 -> out_data=0x05, out_valid at edge e2 after accept.
2. Same parameters; decrypt in_key=0x01, in_data=0x05 -> out_data=0x00. Then back-to-back encrypt/decrypt with out_ready=1 -> issue interval exactly 4 cycles, in_ready low in between.
3. Defaults; 500 random key/data pairs: encrypt then decrypt -> round trip returns the original data; out_data=0 whenever out_valid=0.
4. Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable. Then the handshake -> internal s, k, key_r all 0 at the ZERO cycle; in_ready=1 the next cycle.
5. Abort at RUN round 5 and, separately, abort together with out_ready in DONE -> no out_valid pulse, ZERO then IDLE, registers cleared.
6. Drive rst low asynchronously mid-RUN (between edges) -> outputs reach reset values without a clock edge. After release, a fresh encrypt matches the model.
